// File: rtl/position_estimator_multi_if.sv
// Bus bundle for position_estimator_multi: hall/quadrature/drift-clear inputs
// and the angle, drift and speed results, plus a debug view of the estimator
// state.
//
// Signalling: there is no valid/ready pair on this bus. qdec_inc and qdec_dec
// are single-cycle qualifiers sampled on every rising clk edge. speed_valid
// is a one-cycle strobe with no backpressure: speed_data is meaningful on that
// cycle and holds until the next strobe. All other outputs are level signals
// that update once per clock.
interface position_estimator_multi_if #(
    parameter int THETA_WIDTH = 10,
    parameter int SPEED_WIDTH = 16
);
    logic [2:0]                    hall_uvw;
    logic                          qdec_inc;
    logic                          qdec_dec;
    logic                          drift_clear;
    logic [THETA_WIDTH-1:0]        theta_data;
    logic                          theta_error;
    logic                          theta_uncertain;
    logic                          drift_error;
    logic signed [SPEED_WIDTH-1:0] speed_data;
    logic                          speed_valid;
    logic [1:0]                    est_state;

    // Driver side (motor front-end / bench)
    modport master (
        output hall_uvw, qdec_inc, qdec_dec, drift_clear,
        input  theta_data, theta_error, theta_uncertain, drift_error,
        input  speed_data, speed_valid, est_state
    );

    // Estimator side
    modport slave (
        input  hall_uvw, qdec_inc, qdec_dec, drift_clear,
        output theta_data, theta_error, theta_uncertain, drift_error,
        output speed_data, speed_valid, est_state
    );
endinterface

// File: rtl/position_estimator_multi.sv
// position_estimator_multi: hall + quadrature rotor electrical-angle estimator.
// Filters the raw hall code, snaps theta to the exact hall-edge angle on legal
// single-bit transitions, integrates encoder steps modulo COUNTS_PER_REV in
// between, flags drift between integrated and snapped angle, and (optionally)
// measures signed counts per SPEED_WINDOW clocks.
//
// Build option: define POSITION_ESTIMATOR_SPEED_EN to include the windowed speed
// measurement; without it speed_data and speed_valid are tied to zero.
module position_estimator_multi #(
    parameter int THETA_WIDTH    = 10,
    parameter int COUNTS_PER_REV = 600,
    parameter int FILTER_LEN     = 3,
    parameter int DRIFT_LIMIT    = 8,
    parameter int SPEED_WINDOW   = 1000,
    parameter int SPEED_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    position_estimator_multi_if.slave   bus
);

    // One 30-degree step in encoder counts; every table/edge angle is a multiple.
    localparam int STEP  = COUNTS_PER_REV / 12;
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    // Estimator mode: ERROR (no usable angle), UNCERTAIN (sector table only),
    // LOCKED (edge-snapped and integrating encoder steps).
    typedef enum logic [1:0] {
        ST_ERROR     = 2'd0,
        ST_UNCERTAIN = 2'd1,
        ST_LOCKED    = 2'd2
    } est_state_t;

    est_state_t             state_q, state_d;
    logic [2:0]             raw_q;
    logic [2:0]             filt_q, filt_d;
    logic [2:0]             filt_prev_q;
    logic [CNT_W-1:0]       stab_q, stab_d;
    logic [THETA_WIDTH-1:0] theta_q, theta_d;
    logic                   drift_q, drift_d;

    logic [2:0]             trans;
    logic                   hall_bad;
    logic                   snap_ok;
    logic                   snap_fire;
    logic [3:0]             edge_idx;
    logic [3:0]             sector_idx;
    logic [THETA_WIDTH-1:0] edge_angle;
    logic [THETA_WIDTH-1:0] sector_angle;
    int                     dist_raw;
    int                     dist_circ;
    logic                   drift_set;

    // Multiples of 30 degrees expressed in encoder counts
    function automatic logic [THETA_WIDTH-1:0] idx_to_counts(input logic [3:0] idx);
        return THETA_WIDTH'(int'(idx) * STEP);
    endfunction

    // Hall filter: count consecutive identical raw samples; the filtered code
    // takes the raw value on the sample that completes a run of FILTER_LEN.
    always_comb begin
        stab_d = stab_q;
        filt_d = filt_q;
        if ((bus.hall_uvw == raw_q) && (stab_q != '0)) begin
            if (stab_q < CNT_W'(FILTER_LEN)) begin
                stab_d = stab_q + CNT_W'(1);
            end
        end else begin
            stab_d = CNT_W'(1);
        end
        if (stab_d == CNT_W'(FILTER_LEN)) begin
            filt_d = bus.hall_uvw;
        end
    end

    assign trans    = filt_q ^ filt_prev_q;
    assign hall_bad = (filt_q == 3'b000) || (filt_q == 3'b111);

    // Edge decode: which hall line toggled plus the two steady lines give the
    // exact edge angle; anything else is not snappable.
    always_comb begin
        snap_ok  = 1'b0;
        edge_idx = 4'd0;
        case (trans)
            3'b100: begin
                if (filt_q[1] && !filt_q[0]) begin
                    snap_ok  = 1'b1;
                    edge_idx = 4'd3;
                end else if (!filt_q[1] && filt_q[0]) begin
                    snap_ok  = 1'b1;
                    edge_idx = 4'd9;
                end
            end
            3'b010: begin
                if (filt_q[2] && !filt_q[0]) begin
                    snap_ok  = 1'b1;
                    edge_idx = 4'd1;
                end else if (!filt_q[2] && filt_q[0]) begin
                    snap_ok  = 1'b1;
                    edge_idx = 4'd7;
                end
            end
            3'b001: begin
                if (filt_q[2] && !filt_q[1]) begin
                    snap_ok  = 1'b1;
                    edge_idx = 4'd11;
                end else if (!filt_q[2] && filt_q[1]) begin
                    snap_ok  = 1'b1;
                    edge_idx = 4'd5;
                end
            end
            default: begin
                snap_ok  = 1'b0;
                edge_idx = 4'd0;
            end
        endcase
    end

    // Sector table: mid-sector angle for each legal hall code
    always_comb begin
        case (filt_q)
            3'b100:  sector_idx = 4'd0;
            3'b110:  sector_idx = 4'd2;
            3'b010:  sector_idx = 4'd4;
            3'b011:  sector_idx = 4'd6;
            3'b001:  sector_idx = 4'd8;
            3'b101:  sector_idx = 4'd10;
            default: sector_idx = 4'd0;
        endcase
    end

    assign edge_angle   = idx_to_counts(edge_idx);
    assign sector_angle = idx_to_counts(sector_idx);

    // Next state and next angle, in strict priority order
    always_comb begin
        state_d   = state_q;
        theta_d   = theta_q;
        snap_fire = 1'b0;
        if (hall_bad) begin
            state_d = ST_ERROR;
            theta_d = '0;
        end else if (snap_ok && (state_q != ST_ERROR)) begin
            state_d   = ST_LOCKED;
            theta_d   = edge_angle;
            snap_fire = 1'b1;
        end else if (trans != 3'b000) begin
            state_d = ST_ERROR;
            theta_d = '0;
        end else if (state_q != ST_LOCKED) begin
            state_d = ST_UNCERTAIN;
            theta_d = sector_angle;
        end else if (bus.qdec_inc && !bus.qdec_dec) begin
            theta_d = (theta_q == THETA_WIDTH'(COUNTS_PER_REV - 1)) ? '0
                                                                    : theta_q + THETA_WIDTH'(1);
        end else if (bus.qdec_dec && !bus.qdec_inc) begin
            theta_d = (theta_q == '0) ? THETA_WIDTH'(COUNTS_PER_REV - 1)
                                      : theta_q - THETA_WIDTH'(1);
        end
    end

    // Drift monitor: circular distance between integrated angle and snap target,
    // only meaningful when the integrated angle was already edge-referenced.
    always_comb begin
        dist_raw = int'(theta_q) - int'(edge_angle);
        if (dist_raw < 0) begin
            dist_raw = -dist_raw;
        end
        dist_circ = dist_raw;
        if ((COUNTS_PER_REV - dist_raw) < dist_raw) begin
            dist_circ = COUNTS_PER_REV - dist_raw;
        end
        drift_set = snap_fire && (state_q == ST_LOCKED) && (dist_circ > DRIFT_LIMIT);
        drift_d   = drift_q;
        if (drift_set) begin
            drift_d = 1'b1;
        end else if (bus.drift_clear) begin
            drift_d = 1'b0;
        end
    end

    // Estimator mode register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ERROR;
        end else begin
            state_q <= state_d;
        end
    end

    // Hall filter, angle and drift registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_q       <= 3'b000;
            stab_q      <= '0;
            filt_q      <= 3'b000;
            filt_prev_q <= 3'b000;
            theta_q     <= '0;
            drift_q     <= 1'b0;
        end else begin
            raw_q       <= bus.hall_uvw;
            stab_q      <= stab_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            theta_q     <= theta_d;
            drift_q     <= drift_d;
        end
    end

    // Angle outputs decoded from the mode register
    always_comb begin
        bus.theta_data      = theta_q;
        bus.theta_error     = (state_q == ST_ERROR);
        bus.theta_uncertain = (state_q != ST_LOCKED);
        bus.drift_error     = drift_q;
        bus.est_state       = state_q;
    end

`ifdef POSITION_ESTIMATOR_SPEED_EN
    localparam int WIN_W = (SPEED_WINDOW > 1) ? $clog2(SPEED_WINDOW) : 1;
    localparam logic signed [SPEED_WIDTH-1:0] ACC_MAX = {1'b0, {(SPEED_WIDTH-1){1'b1}}};
    localparam logic signed [SPEED_WIDTH-1:0] ACC_MIN = {1'b1, {(SPEED_WIDTH-1){1'b0}}};

    logic [WIN_W-1:0]              win_q, win_d;
    logic signed [SPEED_WIDTH-1:0] acc_q, acc_step, acc_d;
    logic signed [SPEED_WIDTH-1:0] speed_q, speed_d;
    logic                          valid_q, valid_d;
    logic                          win_last;

    assign win_last = (win_q == WIN_W'(SPEED_WINDOW - 1));

    // Saturating step accumulation and end-of-window capture
    always_comb begin
        acc_step = acc_q;
        if (bus.qdec_inc && !bus.qdec_dec && (acc_q != ACC_MAX)) begin
            acc_step = acc_q + SPEED_WIDTH'(1);
        end else if (bus.qdec_dec && !bus.qdec_inc && (acc_q != ACC_MIN)) begin
            acc_step = acc_q - SPEED_WIDTH'(1);
        end
        if (win_last) begin
            win_d   = '0;
            acc_d   = '0;
            speed_d = acc_step;
            valid_d = 1'b1;
        end else begin
            win_d   = win_q + WIN_W'(1);
            acc_d   = acc_step;
            speed_d = speed_q;
            valid_d = 1'b0;
        end
    end

    // Speed window registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q   <= '0;
            acc_q   <= '0;
            speed_q <= '0;
            valid_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            acc_q   <= acc_d;
            speed_q <= speed_d;
            valid_q <= valid_d;
        end
    end

    assign bus.speed_data  = speed_q;
    assign bus.speed_valid = valid_q;
`else
    // Speed measurement not built
    assign bus.speed_data  = '0;
    assign bus.speed_valid = 1'b0;
`endif

endmodule

// File: doc/position_estimator_multi.md
Name: position_estimator_multi

Overview:
- Parametrised successor of the hall/encoder rotor-angle estimator for the BLDC motor-control path.
- Combines filtered hall sectors with quadrature-decoder steps into an electrical angle modulo an arbitrary encoder resolution (not limited to powers of two).
- Adds a drift monitor at hall edges and a windowed signed speed measurement.
- Feeds the FOC/commutation logic; one instance per motor.

Parameters:
THETA_WIDTH, 10, width of theta_data; 2**THETA_WIDTH >= COUNTS_PER_REV
COUNTS_PER_REV, 600, encoder counts per electrical revolution; must be a multiple of 12
FILTER_LEN, 3, consecutive identical hall samples required before the filtered hall value updates (>=1)
DRIFT_LIMIT, 8, max allowed circular |theta - snap target| at a hall edge, in counts
SPEED_WINDOW, 1000, clk cycles per speed measurement window
SPEED_WIDTH, 16, width of speed_data (signed)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
hall_uvw  in  3  raw hall inputs {U,V,W}
qdec_inc  in  1  one-cycle pulse, +1 count
qdec_dec  in  1  one-cycle pulse, -1 count
drift_clear  in  1  clears sticky drift_error
theta_data  out  THETA_WIDTH  electrical angle, 0..COUNTS_PER_REV-1
theta_error  out  1  hall invalid or illegal transition
theta_uncertain  out  1  angle from sector table only (no edge seen yet)
drift_error  out  1  sticky; set on a snap exceeding DRIFT_LIMIT
speed_data  out  SPEED_WIDTH  signed net counts in the last window
speed_valid  out  1  one-cycle pulse when speed_data updates

Behaviour:
- Reset values: theta_data=0, theta_error=1, theta_uncertain=1, drift_error=0, speed_data=0, speed_valid=0. Internal: filtered hall=000, previous filtered hall=000, stability counter=0, window counter=0, accumulator=0.
- Notation: C=COUNTS_PER_REV; angle a° maps to a*C/360 counts.
- Hall filter: the filtered hall value takes the raw value on the clock edge at which the raw value has been identical for FILTER_LEN consecutive samples. transition = filtered XOR previous filtered (both registered). theta reacts one clock after the filtered hall changes.
- Sector table, filtered UVW -> angle:
  - 100=0°, 110=60°, 010=120°, 011=180°, 001=240°, 101=300°.
  - 000 and 111 are errors.
- theta update priority, highest first:
  1. Filtered hall is 000 or 111 -> theta=0, error=1, uncertain=1.
  2. Single-bit transition, current error=0 -> snap to edge angle; error=0, uncertain=0:
     - U change: V=1,W=0 -> 90°; V=0,W=1 -> 270°.
     - V change: U=1,W=0 -> 30°; U=0,W=1 -> 210°.
     - W change: U=1,V=0 -> 330°; U=0,V=1 -> 150°.
  3. Any other non-zero transition -> theta=0, error=1, uncertain=1.
  4. uncertain=1 -> theta=table[filtered]; error=0, uncertain stays 1.
  5. qdec_inc only -> +1, with C-1 wrapping to 0. qdec_dec only -> -1, with 0 wrapping to C-1. Both or neither -> hold.
- qdec pulses in a cycle that takes priority 1-4 are dropped for theta but still counted for speed.
- Drift check:
  - Applies on a priority-2 snap while the pre-update uncertain=0.
  - d = circular distance between the pre-update theta_data and the target, min(|x-y|, C-|x-y|).
  - d > DRIFT_LIMIT sets drift_error. drift_clear clears it; a set in the same cycle wins.
- Speed:
  - Signed accumulator takes +1/-1 per qdec cycle (both pulses -> 0) and saturates at the SPEED_WIDTH signed limits.
  - On the last cycle of each SPEED_WINDOW window: speed_data = accumulator including that cycle's step, accumulator returns to 0, speed_valid=1 for one cycle.
  - The window runs freely from reset.
- Reset asserted mid-operation returns every register to its reset value immediately.

Optional Feature:
POSITION_ESTIMATOR_SPEED_EN:
- Defined: speed accumulator, window counter and outputs as above.
- Undefined: no speed logic synthesised; speed_data=0 and speed_valid=0 constantly. Angle and drift behaviour unchanged.

Test Plan (defaults unless stated; C=600):
1. Reset, hall=110 held -> theta_data=100, error=0, uncertain=1 on the edge FILTER_LEN+2 after reset release; drift_error=0.
2. From 1, hall 110->010 -> theta=150, uncertain=0; then 10 qdec_inc pulses -> theta=160; inc+dec in the same cycle -> theta stays 160.
3. Hall 101->100 -> theta=550. 49 inc -> 599, 1 inc -> 0, 1 dec -> 599, 1 inc -> 0.
4. Snap at 150 (hall 110->010), 30 inc (theta=180), hall 010->011 -> theta=250, drift_error=1 (d=70); stays set until drift_clear, then 0. A snap with d<=8 leaves it 0.
5. Raw hall glitch shorter than FILTER_LEN -> no change. Jump 110->011 -> error=1, uncertain=1, theta=0, then theta=300, uncertain=1. Hall 111 -> error=1, theta=0.
6. SPEED_WINDOW=100, with POSITION_ESTIMATOR_SPEED_EN: 25 inc in a window -> speed_data=25 with one speed_valid pulse; next window 10 dec -> speed_data=-10. Without the macro: speed_data=0, speed_valid never 1.
